// File: rtl/dm_store_buffer_pkg.sv
// Shared types and default sizes for the data-memory store buffer.
package lsu_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_ADDR_W = 8;
  localparam int unsigned SB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LD_RD  = 2'd1,
    LD_RSP = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/dm_store_buffer_if.sv
// Request/response and data-memory port bundle of the store buffer.
interface dm_store_buffer_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
);

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_data;
  logic              dm_rden;
  logic              dm_wren;
  logic [DATA_W-1:0] dm_q;
  logic              sb_empty;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, dm_q,
    input  req_ready, rsp_valid, rsp_rdata, dm_address, dm_data, dm_rden, dm_wren, sb_empty
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, dm_q,
    output req_ready, rsp_valid, rsp_rdata, dm_address, dm_data, dm_rden, dm_wren, sb_empty
  );

endinterface

// File: rtl/dm_store_buffer_sb_fifo.sv
// In-order store-buffer storage with wrap-bit pointers and youngest-match forwarding lookup.
module sb_fifo
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [SB_ADDR_W-1:0] wr_addr_i,
  input  logic [SB_DATA_W-1:0] wr_data_i,
  input  logic                 pop_i,
  input  logic [SB_ADDR_W-1:0] lookup_addr_i,
  output logic [SB_ADDR_W-1:0] head_addr_c_o,
  output logic [SB_DATA_W-1:0] head_data_c_o,
  output logic                 hit_c_o,
  output logic [SB_DATA_W-1:0] hit_data_c_o,
  output logic                 full_c_o,
  output logic                 empty_c_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  sb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] head_idx, tail_idx, slot;
  logic             do_push, do_pop;

  assign head_idx  = head_q[IDX_W-1:0];
  assign tail_idx  = tail_q[IDX_W-1:0];
  assign empty_c_o = (head_q == tail_q);
  assign full_c_o  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign do_push   = push_i && !full_c_o;
  assign do_pop    = pop_i && !empty_c_o;

  assign head_addr_c_o = mem_q[head_idx].addr;
  assign head_data_c_o = mem_q[head_idx].data;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (do_push) tail_d = tail_q + PTR_W'(1);
    if (do_pop)  head_d = head_q + PTR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (do_push) mem_q[tail_idx] <= '{valid: 1'b1, addr: wr_addr_i, data: wr_data_i};
      if (do_pop)  mem_q[head_idx].valid <= 1'b0;
    end
  end

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    hit_c_o      = 1'b0;
    hit_data_c_o = '0;
    slot         = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head_idx + IDX_W'(k);
      if (mem_q[slot].valid && (mem_q[slot].addr == lookup_addr_i)) begin
        hit_c_o      = 1'b1;
        hit_data_c_o = mem_q[slot].data;
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Load/store front-end for DM: posts stores into a draining buffer, serves loads with forwarding.
module dm_store_buffer
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input logic              clock,
  input logic              reset,
  dm_store_buffer_if.slave bus
);

  lsu_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic                 ready_c, accept_c, push_c, drain_c;
  logic                 full_c, empty_c, hit_c;
  logic [SB_DATA_W-1:0] hit_data_c;
  logic [SB_ADDR_W-1:0] head_addr_c;
  logic [SB_DATA_W-1:0] head_data_c;
  logic [ADDR_W-1:0]    dm_address_c;
  logic [DATA_W-1:0]    dm_data_c;
  logic                 dm_rden_c;

  sb_fifo #(.DEPTH(DEPTH)) u_sb_fifo (
    .clock         (clock),
    .reset         (reset),
    .push_i        (push_c),
    .wr_addr_i     (SB_ADDR_W'(bus.req_addr)),
    .wr_data_i     (SB_DATA_W'(bus.req_wdata)),
    .pop_i         (drain_c),
    .lookup_addr_i (SB_ADDR_W'(ld_addr_q)),
    .head_addr_c_o (head_addr_c),
    .head_data_c_o (head_data_c),
    .hit_c_o       (hit_c),
    .hit_data_c_o  (hit_data_c),
    .full_c_o      (full_c),
    .empty_c_o     (empty_c)
  );

  // Next state, load capture and DM port decode; the buffer is frozen while DM is being read.
  always_comb begin
    state_d      = state_q;
    ld_addr_d    = ld_addr_q;
    rsp_rdata_d  = rsp_rdata_q;
    ready_c      = (state_q == IDLE) && !full_c;
    accept_c     = bus.req_valid && ready_c;
    push_c       = accept_c && bus.req_we;
    drain_c      = (state_q != LD_RD) && !empty_c;
    dm_rden_c    = 1'b0;
    dm_address_c = '0;
    dm_data_c    = '0;

    case (state_q)
      IDLE: begin
        if (accept_c && !bus.req_we) begin
          ld_addr_d = bus.req_addr;
          state_d   = LD_RD;
        end
      end
      LD_RD: begin
        rsp_rdata_d = hit_c ? DATA_W'(hit_data_c) : bus.dm_q;
        state_d     = LD_RSP;
      end
      LD_RSP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == LD_RD) begin
      dm_rden_c    = 1'b1;
      dm_address_c = ld_addr_q;
    end else if (drain_c) begin
      dm_address_c = ADDR_W'(head_addr_c);
      dm_data_c    = DATA_W'(head_data_c);
    end

    rsp_valid_d = (state_d == LD_RSP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ld_addr_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_addr_q   <= ld_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.dm_address = dm_address_c;
  assign bus.dm_data    = dm_data_c;
  assign bus.dm_rden    = dm_rden_c;
  assign bus.dm_wren    = drain_c;
  assign bus.sb_empty   = empty_c;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: DM memory model, program-order reference model, directed and random scenarios.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  dm_store_buffer_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  dm_store_buffer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] mem  [256];
  logic [31:0] arch [256];
  wr_t         sbq[$];
  wr_t         wr_exp[$];
  wr_t         wr_seen[$];
  int          phase = 0;
  logic [7:0]  ld_addr_m = '0;
  logic [31:0] ld_exp = '0;
  bit          last_acc = 1'b0;
  bit          chk_en = 1'b0;
  bit          m_rdy, m_drn, m_acc;
  bit          e_ready, e_drain, e_rden;
  logic [7:0]  e_addr;
  logic [31:0] e_data;

  // DM: write and read both resolve on the falling edge.
  always @(negedge clock) begin
    if (bus.dm_wren === 1'b1) begin
      mem[bus.dm_address] = bus.dm_data;
      wr_seen.push_back('{addr: bus.dm_address, data: bus.dm_data});
    end
    if (bus.dm_rden === 1'b1) bus.dm_q = mem[bus.dm_address];
  end

  // Reference model: pending-store queue, program-order memory image, load phase counter.
  always @(posedge clock) begin
    last_acc = 1'b0;
    if (reset) begin
      sbq.delete();
      phase = 0;
    end else begin
      m_rdy = (phase == 0) && (sbq.size() < DEPTH);
      m_drn = (phase != 1) && (sbq.size() != 0);
      m_acc = bus.req_valid && m_rdy;
      last_acc = m_acc;
      if (m_drn) wr_exp.push_back(sbq.pop_front());
      if (m_acc && bus.req_we) begin
        sbq.push_back('{addr: bus.req_addr, data: bus.req_wdata});
        arch[bus.req_addr] = bus.req_wdata;
      end
      case (phase)
        0: if (m_acc && !bus.req_we) begin
             ld_addr_m = bus.req_addr;
             ld_exp    = arch[bus.req_addr];
             phase     = 1;
           end
        1: phase = 2;
        default: phase = 0;
      endcase
    end
  end

  // Per-cycle scoreboard of every output against the model.
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      e_ready = (phase == 0) && (sbq.size() < DEPTH);
      e_drain = (phase != 1) && (sbq.size() != 0);
      e_rden  = (phase == 1);
      e_addr  = '0;
      e_data  = '0;
      if (e_rden) e_addr = ld_addr_m;
      else if (e_drain) begin
        e_addr = sbq[0].addr;
        e_data = sbq[0].data;
      end
      n_checks++;
      if (bus.req_ready !== e_ready) begin n_fail++; $display("FAIL req_ready t=%0t got %b exp %b", $time, bus.req_ready, e_ready); end
      n_checks++;
      if (bus.dm_wren !== e_drain) begin n_fail++; $display("FAIL dm_wren t=%0t got %b exp %b", $time, bus.dm_wren, e_drain); end
      n_checks++;
      if (bus.dm_rden !== e_rden) begin n_fail++; $display("FAIL dm_rden t=%0t got %b exp %b", $time, bus.dm_rden, e_rden); end
      n_checks++;
      if (bus.dm_address !== e_addr) begin n_fail++; $display("FAIL dm_address t=%0t got %h exp %h", $time, bus.dm_address, e_addr); end
      n_checks++;
      if (bus.dm_data !== e_data) begin n_fail++; $display("FAIL dm_data t=%0t got %h exp %h", $time, bus.dm_data, e_data); end
      n_checks++;
      if (bus.sb_empty !== (sbq.size() == 0)) begin n_fail++; $display("FAIL sb_empty t=%0t got %b exp %b", $time, bus.sb_empty, sbq.size() == 0); end
      n_checks++;
      if (bus.rsp_valid !== (phase == 2)) begin n_fail++; $display("FAIL rsp_valid t=%0t got %b exp %b", $time, bus.rsp_valid, phase == 2); end
      if (phase == 2) begin
        n_checks++;
        if (bus.rsp_rdata !== ld_exp) begin n_fail++; $display("FAIL rsp_rdata t=%0t addr %h got %h exp %h", $time, ld_addr_m, bus.rsp_rdata, ld_exp); end
      end
    end
  end

  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  // Hold a request until the model reports acceptance; returns just after the accepting edge.
  task automatic send(input bit we, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!last_acc && n < 50);
    n_checks++;
    if (!last_acc) begin n_fail++; $display("FAIL send_timeout we=%b addr %h waited %0d cycles", we, a, n); end
    idle_req();
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge clock);
    while (bus.sb_empty !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (bus.sb_empty !== 1'b1) begin n_fail++; $display("FAIL wait_empty got %b exp 1", bus.sb_empty); end
  endtask

  task automatic test_reset();
    idle_req();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata got %h exp 0", bus.rsp_rdata); end
    n_checks++; if (bus.sb_empty !== 1'b1) begin n_fail++; $display("FAIL rst_sb_empty got %b exp 1", bus.sb_empty); end
    n_checks++; if ({bus.dm_rden, bus.dm_wren} !== 2'b00) begin n_fail++; $display("FAIL rst_dm_en got %b exp 00", {bus.dm_rden, bus.dm_wren}); end
    n_checks++; if (bus.dm_address !== 8'h0 || bus.dm_data !== 32'h0) begin n_fail++; $display("FAIL rst_dm_bus got %h/%h exp 0/0", bus.dm_address, bus.dm_data); end
    chk_en = 1'b1;
  endtask

  task automatic test_store_drain();
    send(1'b1, 8'd5, 32'h1234);
    @(negedge clock);
    n_checks++; if (bus.dm_wren !== 1'b1 || bus.dm_address !== 8'd5 || bus.dm_data !== 32'h1234) begin
      n_fail++; $display("FAIL drain_port got wren=%b addr=%h data=%h exp 1/05/00001234", bus.dm_wren, bus.dm_address, bus.dm_data); end
    @(negedge clock);
    n_checks++; if (bus.sb_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", bus.sb_empty); end
    n_checks++; if (mem[5] !== 32'h1234) begin n_fail++; $display("FAIL drain_dm got %h exp 00001234", mem[5]); end
  endtask

  task automatic test_load_miss();
    wait_empty();
    mem[3]  = 32'hFFFF_FFF7;
    arch[3] = 32'hFFFF_FFF7;
    send(1'b0, 8'd3, 32'h0);
    @(negedge clock);
    n_checks++; if (bus.dm_rden !== 1'b1 || bus.dm_wren !== 1'b0 || bus.dm_address !== 8'd3) begin
      n_fail++; $display("FAIL miss_rd got rden=%b wren=%b addr=%h exp 1/0/03", bus.dm_rden, bus.dm_wren, bus.dm_address); end
    @(negedge clock);
    n_checks++; if (bus.dm_rden !== 1'b0 || bus.rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL miss_rsp got rden=%b rsp_valid=%b exp 0/1", bus.dm_rden, bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'hFFFF_FFF7) begin n_fail++; $display("FAIL miss_data got %h exp fffffff7", bus.rsp_rdata); end
    @(negedge clock);
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.dm_rden !== 1'b0) begin
      n_fail++; $display("FAIL miss_pulse got rsp_valid=%b rden=%b exp 0/0", bus.rsp_valid, bus.dm_rden); end
  endtask

  task automatic test_forwarding();
    int n = 0;
    send(1'b0, 8'h20, 32'h0);
    send(1'b1, 8'd7, 32'hA);
    send(1'b1, 8'd7, 32'hB);
    send(1'b0, 8'd7, 32'h0);
    do begin
      @(negedge clock);
      n++;
    end while (bus.rsp_valid !== 1'b1 && n < 10);
    n_checks++; if (n != 2) begin n_fail++; $display("FAIL fwd_latency got %0d negedges exp 2", n); end
    n_checks++; if (bus.rsp_rdata !== 32'hB) begin n_fail++; $display("FAIL fwd_data got %h exp 0000000b", bus.rsp_rdata); end
  endtask

  task automatic test_full();
    logic [31:0] vals [DEPTH+1];
    int base;
    for (int i = 0; i <= DEPTH; i++) begin
      vals[i] = $urandom();
      send(1'b0, 8'($urandom_range(64, 95)), 32'h0);
      send(1'b1, 8'(8'hF0 + i), vals[i]);
    end
    wait_empty();
    base = wr_seen.size() - (DEPTH + 1);
    for (int i = 0; i <= DEPTH; i++) begin
      n_checks++;
      if (base < 0 || wr_seen[base+i].addr !== 8'(8'hF0 + i) || wr_seen[base+i].data !== vals[i]) begin
        n_fail++; $display("FAIL full_order idx %0d exp %h/%h", i, 8'(8'hF0 + i), vals[i]); end
      n_checks++;
      if (mem[8'hF0 + i] !== vals[i]) begin n_fail++; $display("FAIL full_dm idx %0d got %h exp %h", i, mem[8'hF0 + i], vals[i]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.req_we    = ($urandom_range(0, 1) == 1);
      bus.req_addr  = 8'($urandom_range(16, 23));
      bus.req_wdata = $urandom();
      @(posedge clock); #1;
    end
    idle_req();
    wait_empty();
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (mem[a] !== arch[a]) begin n_fail++; $display("FAIL rand_dm addr %h got %h exp %h", a, mem[a], arch[a]); end
    end
  endtask

  task automatic test_reset_mid_load();
    int wr_cnt;
    wait_empty();
    send(1'b1, 8'h30, 32'h55);
    send(1'b1, 8'h31, 32'h66);
    send(1'b0, 8'h30, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    wr_cnt = wr_seen.size();
    @(negedge clock);
    n_checks++; if (bus.sb_empty !== 1'b1) begin n_fail++; $display("FAIL rml_empty got %b exp 1", bus.sb_empty); end
    n_checks++; if ({bus.dm_rden, bus.dm_wren} !== 2'b00 || bus.dm_address !== 8'h0 || bus.dm_data !== 32'h0) begin
      n_fail++; $display("FAIL rml_dm got %b%b %h %h exp 00 00 00000000", bus.dm_rden, bus.dm_wren, bus.dm_address, bus.dm_data); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rml_rdata got %h exp 0", bus.rsp_rdata); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rml_rsp_valid cycle %0d got %b exp 0", i, bus.rsp_valid); end
      @(negedge clock);
    end
    n_checks++; if (wr_seen.size() != wr_cnt) begin n_fail++; $display("FAIL rml_no_write got %0d writes exp %0d", wr_seen.size(), wr_cnt); end
    for (int a = 0; a < 256; a++) arch[a] = mem[a];
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]  = $urandom();
      arch[a] = mem[a];
    end
    idle_req();
    test_reset();
    test_store_drain();
    test_load_miss();
    test_forwarding();
    test_full();
    test_random();
    test_reset_mid_load();
    test_store_drain();
    n_checks++;
    if (wr_seen.size() != wr_exp.size()) begin n_fail++; $display("FAIL write_count got %0d exp %0d", wr_seen.size(), wr_exp.size()); end
    for (int i = 0; i < wr_seen.size() && i < wr_exp.size(); i++) begin
      n_checks++;
      if (wr_seen[i] !== wr_exp[i]) begin n_fail++; $display("FAIL write_seq idx %0d got %h exp %h", i, wr_seen[i], wr_exp[i]); end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
